// File: rtl/d_flip.sv
// rtl/d_flip.sv - parameterised D register with complemented output, async reset, sync clear and enable
module d_flip #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // Clear outranks enable so a stalled stage can still be flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (clr) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

    // Derived from the one register so q and qb can never disagree.
    assign qb = ~q;

endmodule

// File: tb/tb_d_flip.sv
// tb/tb_d_flip.sv - self-checking bench for d_flip, narrow and wide instances against a reference model
module tb_d_flip;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic       qb1;
    logic [7:0] q8;
    logic [7:0] qb8;

    int total = 0;
    int bad   = 0;

    logic       m1;
    logic [7:0] m8;

    always #5 clk = ~clk;

    d_flip #(.WIDTH(1)) u_narrow (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .d    (d1),
        .q    (q1),
        .qb   (qb1)
    );

    d_flip #(.WIDTH(8), .RESET_VALUE(RV8)) u_wide (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (clr),
        .d    (d8),
        .q    (q8),
        .qb   (qb8)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q1"},  {7'b0, q1},  {7'b0, m1});
        chk({tag, ".qb1"}, {7'b0, qb1}, {7'b0, ~m1});
        chk({tag, ".q8"},  q8,  m8);
        chk({tag, ".qb8"}, qb8, ~m8);
    endtask

    // Reference register: what a rising edge should do given the inputs held across it.
    task automatic clock_edge();
        @(posedge clk);
        if (!rst_n) begin
            m1 = 1'b0;
            m8 = RV8;
        end else if (clr) begin
            m1 = 1'b0;
            m8 = RV8;
        end else if (en) begin
            m1 = d1;
            m8 = d8;
        end
        #1;
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m1 = 1'b0;
        m8 = RV8;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        clr   = 1'b0;
        d1    = 1'b1;
        d8    = 8'hFF;
        m1    = 1'b0;
        m8    = RV8;

        // Reset asserted mid-cycle, then edges while held low
        #2;
        async_reset("reset_immediate");
        for (int i = 0; i < 3; i++) begin
            d1 = 1'b1;
            d8 = 8'($urandom);
            clock_edge();
            check_all("reset_held");
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset_release_no_edge");

        // Basic capture
        @(negedge clk);
        en = 1'b1; clr = 1'b0; d1 = 1'b0; d8 = 8'h00;
        clock_edge();
        check_all("capture0");
        @(negedge clk);
        d1 = 1'b1; d8 = 8'h3C;
        clock_edge();
        check_all("capture1");
        @(negedge clk);
        d1 = 1'b0; d8 = 8'hFF;
        #2;
        check_all("between_edges");
        d1 = 1'b1; d8 = 8'h3C;
        #1;
        d1 = 1'b0; d8 = 8'hE1;
        clock_edge();
        check_all("capture_after_toggle");

        // Enable hold
        @(negedge clk);
        d1 = 1'b1; d8 = 8'h81;
        clock_edge();
        check_all("hold_setup");
        @(negedge clk);
        en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            check_all("hold");
        end
        @(negedge clk);
        en = 1'b1;
        clock_edge();
        check_all("hold_release");

        // Synchronous clear beats enable state
        @(negedge clk);
        d1 = 1'b1; d8 = 8'h77;
        clock_edge();
        check_all("clr_setup");
        @(negedge clk);
        clr = 1'b1; en = 1'b0; d1 = 1'b1; d8 = 8'h3C;
        clock_edge();
        check_all("sync_clear");
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        clock_edge();
        check_all("after_clear");

        // Async reset two time units after an edge
        #1;
        async_reset("async_mid_op");
        @(negedge clk);
        rst_n = 1'b1; d1 = 1'b1; d8 = 8'h3C;
        clock_edge();
        check_all("after_async");

        // Randomised traffic with occasional mid-cycle resets
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            en    = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 7) == 0);
            d1    = 1'($urandom);
            d8    = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                #2;
                async_reset("rnd_async");
            end
            clock_edge();
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
